// File: rtl/disaster_alert_ctrl.sv
// Alarm sequencer: per-hazard persistence filter, confirmed-alarm latch, LED panel
// drive and the buzzer alert / acknowledge / auto-clear state machine.
module disaster_alert_ctrl #(
    parameter int PERSIST  = 3,
    parameter int CLEAR    = 4,
    parameter int BEEP_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] haz,
    input  logic       mode,
    input  logic       ack,
    output logic [3:0] led,
    output logic       buzzer,
    output logic       alarm,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ALERT = 2'b01,
        S_ACKED = 2'b10
    } state_t;

    localparam logic [3:0] PERSIST_C = 4'(PERSIST);
    localparam logic [3:0] CLEAR_C   = 4'(CLEAR);
    localparam logic [3:0] BEEP_C    = 4'(BEEP_DIV);

    state_t     state_q;
    logic [3:0] pc_q [4];
    logic [3:0] pc_d [4];
    logic [3:0] conf;
    logic [3:0] latched_q, latched_d;
    logic [3:0] acked_mask_q;
    logic [3:0] clr_cnt_q;
    logic [3:0] beep_cnt_q;
    logic       buzzer_q;

    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? lim : v + 4'd1;
    endfunction

    // A single tick without the hazard forfeits all accumulated credit.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pc_d[i] = pc_q[i];
            if (tick) begin
                pc_d[i] = haz[i] ? sat_inc(pc_q[i], PERSIST_C) : 4'd0;
            end
            conf[i] = (pc_q[i] == PERSIST_C);
        end
    end

    assign latched_d = latched_q | conf;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                pc_q[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                pc_q[i] <= pc_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            latched_q    <= 4'd0;
            acked_mask_q <= 4'd0;
            clr_cnt_q    <= 4'd0;
            beep_cnt_q   <= 4'd0;
            buzzer_q     <= 1'b0;
        end else begin
            latched_q <= latched_d;
            case (state_q)
                S_IDLE: begin
                    if (|conf) begin
                        state_q    <= S_ALERT;
                        buzzer_q   <= 1'b1;
                        beep_cnt_q <= 4'd0;
                    end
                end
                S_ALERT: begin
                    if (ack) begin
                        state_q      <= S_ACKED;
                        acked_mask_q <= latched_q | conf;
                        buzzer_q     <= 1'b0;
                        clr_cnt_q    <= 4'd0;
                    end else if (tick) begin
                        if (beep_cnt_q + 4'd1 >= BEEP_C) begin
                            buzzer_q   <= ~buzzer_q;
                            beep_cnt_q <= 4'd0;
                        end else begin
                            beep_cnt_q <= beep_cnt_q + 4'd1;
                        end
                    end
                end
                S_ACKED: begin
                    buzzer_q <= 1'b0;
                    // An unacknowledged confirmation outranks the quiet-period countdown.
                    if (|(conf & ~acked_mask_q)) begin
                        state_q    <= S_ALERT;
                        buzzer_q   <= 1'b1;
                        beep_cnt_q <= 4'd0;
                    end else if (tick) begin
                        if (haz != 4'd0) begin
                            clr_cnt_q <= 4'd0;
                        end else if (clr_cnt_q + 4'd1 >= CLEAR_C) begin
                            state_q      <= S_IDLE;
                            latched_q    <= 4'd0;
                            acked_mask_q <= 4'd0;
                            clr_cnt_q    <= 4'd0;
                        end else begin
                            clr_cnt_q <= clr_cnt_q + 4'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        led = 4'd0;
        if (mode) begin
            led = latched_q;
        end else if (latched_q[3]) begin
            led = 4'b1000;
        end else if (latched_q[2]) begin
            led = 4'b0100;
        end else if (latched_q[1]) begin
            led = 4'b0010;
        end else if (latched_q[0]) begin
            led = 4'b0001;
        end
    end

    assign buzzer = buzzer_q;
    assign state  = state_q;
    assign alarm  = (state_q != S_IDLE);

endmodule

// File: tb/tb_disaster_alert_ctrl.sv
// Bench for disaster_alert_ctrl: cycle vectors with hand-derived expectations,
// queued at drive time and compared once the clock edge has produced outputs.
module tb_disaster_alert_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] haz = 4'd0;
    logic       mode = 1'b0;
    logic       ack = 1'b0;
    logic [3:0] led;
    logic       buzzer;
    logic       alarm;
    logic [1:0] state;

    disaster_alert_ctrl #(.PERSIST(3), .CLEAR(4), .BEEP_DIV(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .haz   (haz),
        .mode  (mode),
        .ack   (ack),
        .led   (led),
        .buzzer(buzzer),
        .alarm (alarm),
        .state (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       tick;
        logic [3:0] haz;
        logic       mode;
        logic       ack;
        logic [1:0] st;
        logic       bz;
        logic [3:0] led;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic r, input logic t, input logic [3:0] h, input logic m,
                       input logic a, input logic [1:0] s, input logic b, input logic [3:0] l);
        vec_t v;
        v.rst = r; v.tick = t; v.haz = h; v.mode = m; v.ack = a;
        v.st = s; v.bz = b; v.led = l;
        vecs.push_back(v);
    endtask

    task automatic apply(input int idx, input vec_t v);
        vec_t e;
        rst = v.rst; tick = v.tick; haz = v.haz; mode = v.mode; ack = v.ack;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_vec++;
        if (state !== e.st) begin
            n_err++;
            $display("FAIL vec%0d state: got %b want %b", idx, state, e.st);
        end
        if (buzzer !== e.bz) begin
            n_err++;
            $display("FAIL vec%0d buzzer: got %b want %b", idx, buzzer, e.bz);
        end
        if (led !== e.led) begin
            n_err++;
            $display("FAIL vec%0d led: got %b want %b", idx, led, e.led);
        end
        if (alarm !== (e.st != 2'b00)) begin
            n_err++;
            $display("FAIL vec%0d alarm: got %b want %b", idx, alarm, (e.st != 2'b00));
        end
    endtask

    task automatic chk_led(input string name, input logic [3:0] want);
        n_vec++;
        if (led !== want) begin
            n_err++;
            $display("FAIL %s: got %b want %b", name, led, want);
        end
    endtask

    initial begin
        bit got;
        //   rst tick haz     mode ack  state bz led
        add(1, 0, 4'b0000, 0, 0, 2'd0, 0, 4'b0000);
        // flood confirmed after three ticks, with idle clocks between ticks
        add(0, 1, 4'b1000, 0, 0, 2'd0, 0, 4'b0000);
        add(0, 0, 4'b1000, 0, 0, 2'd0, 0, 4'b0000);
        add(0, 1, 4'b1000, 0, 0, 2'd0, 0, 4'b0000);
        add(0, 1, 4'b1000, 0, 0, 2'd0, 0, 4'b0000);
        add(0, 0, 4'b1000, 0, 0, 2'd1, 1, 4'b1000);
        add(0, 1, 4'b1000, 0, 0, 2'd1, 1, 4'b1000);
        add(0, 0, 4'b1000, 0, 0, 2'd1, 1, 4'b1000);
        add(0, 1, 4'b1000, 0, 0, 2'd1, 0, 4'b1000);
        add(0, 1, 4'b1000, 0, 0, 2'd1, 0, 4'b1000);
        add(0, 1, 4'b1000, 0, 0, 2'd1, 1, 4'b1000);
        // acknowledge, then clear countdown interrupted by one hazard tick
        add(0, 0, 4'b1000, 0, 1, 2'd2, 0, 4'b1000);
        add(0, 1, 4'b0000, 0, 0, 2'd2, 0, 4'b1000);
        add(0, 1, 4'b0000, 0, 0, 2'd2, 0, 4'b1000);
        add(0, 1, 4'b0000, 0, 0, 2'd2, 0, 4'b1000);
        add(0, 1, 4'b0001, 0, 0, 2'd2, 0, 4'b1000);
        add(0, 1, 4'b0000, 0, 0, 2'd2, 0, 4'b1000);
        add(0, 1, 4'b0000, 0, 0, 2'd2, 0, 4'b1000);
        add(0, 1, 4'b0000, 0, 0, 2'd2, 0, 4'b1000);
        add(0, 1, 4'b0000, 0, 0, 2'd0, 0, 4'b0000);
        add(0, 0, 4'b0000, 0, 1, 2'd0, 0, 4'b0000);
        // cyclone drops out before reaching persistence
        add(0, 1, 4'b0100, 0, 0, 2'd0, 0, 4'b0000);
        add(0, 1, 4'b0100, 0, 0, 2'd0, 0, 4'b0000);
        add(0, 1, 4'b0000, 0, 0, 2'd0, 0, 4'b0000);
        add(0, 1, 4'b0100, 0, 0, 2'd0, 0, 4'b0000);
        add(0, 1, 4'b0100, 0, 0, 2'd0, 0, 4'b0000);
        add(0, 1, 4'b0000, 0, 0, 2'd0, 0, 4'b0000);
        // two hazards, unique vs multi display, then ack
        add(0, 1, 4'b0011, 0, 0, 2'd0, 0, 4'b0000);
        add(0, 1, 4'b0011, 0, 0, 2'd0, 0, 4'b0000);
        add(0, 1, 4'b0011, 0, 0, 2'd0, 0, 4'b0000);
        add(0, 0, 4'b0011, 0, 0, 2'd1, 1, 4'b0010);
        add(0, 0, 4'b0011, 1, 0, 2'd1, 1, 4'b0011);
        add(0, 0, 4'b0011, 0, 0, 2'd1, 1, 4'b0010);
        add(0, 0, 4'b0011, 0, 1, 2'd2, 0, 4'b0010);
        // new flood confirmation re-alerts from ACKED; ack in ACKED ignored
        add(0, 1, 4'b1010, 0, 0, 2'd2, 0, 4'b0010);
        add(0, 1, 4'b1010, 0, 1, 2'd2, 0, 4'b0010);
        add(0, 1, 4'b1010, 0, 0, 2'd2, 0, 4'b0010);
        add(0, 0, 4'b1010, 0, 0, 2'd1, 1, 4'b1000);
        add(0, 0, 4'b1010, 0, 1, 2'd2, 0, 4'b1000);
        add(0, 0, 4'b1010, 1, 0, 2'd2, 0, 4'b1011);
        // cyclone re-alert, then reset mid-ALERT with buzzer on
        add(0, 1, 4'b1110, 0, 0, 2'd2, 0, 4'b1000);
        add(0, 1, 4'b1110, 0, 0, 2'd2, 0, 4'b1000);
        add(0, 1, 4'b1110, 0, 0, 2'd2, 0, 4'b1000);
        add(0, 0, 4'b1110, 0, 0, 2'd1, 1, 4'b1000);
        add(1, 1, 4'b1110, 0, 0, 2'd0, 0, 4'b0000);
        add(0, 1, 4'b1110, 0, 0, 2'd0, 0, 4'b0000);
        add(0, 1, 4'b1110, 0, 0, 2'd0, 0, 4'b0000);
        add(0, 1, 4'b1110, 0, 0, 2'd0, 0, 4'b0000);
        add(0, 0, 4'b1110, 0, 0, 2'd1, 1, 4'b1000);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        // mode switch reflects on led without a clock edge
        mode = 1'b1;
        #1;
        chk_led("mode1_same_cycle", 4'b1110);
        mode = 1'b0;
        #1;
        chk_led("mode0_same_cycle", 4'b1000);

        // ack must reach ACKED within a bounded number of clocks
        ack = 1'b1;
        tick = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 5 && !got; k++) begin
            @(posedge clk);
            #1;
            if (state == 2'd2) got = 1'b1;
        end
        ack = 1'b0;
        n_vec++;
        if (!got || buzzer !== 1'b0) begin
            n_err++;
            $display("FAIL ack_timeout: state %b buzzer %b, want 10 and 0", state, buzzer);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/disaster_alert_ctrl.md
Name: disaster_alert_ctrl

Overview:
Alarm sequencer that sits downstream of the disaster detection logic. It takes the four raw hazard detections (flood, cyclone, earthquake, tsunami) and filters them for persistence over a slow sample tick. It latches confirmed alarms, drives the LED panel in unique or multi mode, and runs a buzzer alert / operator-acknowledge / auto-clear state machine.

Parameters:
PERSIST, 3, consecutive ticks a hazard must stay asserted to be confirmed (legal range 1..15)
CLEAR, 4, consecutive hazard-free ticks in ACKED before returning to IDLE (legal range 1..15)
BEEP_DIV, 2, ticks per buzzer half-period in ALERT (legal range 1..15)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
tick  input  1  single-cycle sample strobe; all filtering and timing advance only on cycles where tick=1
haz  input  4  raw detections: [3]=flood, [2]=cyclone, [1]=earthquake, [0]=tsunami
mode  input  1  0 = unique display (highest priority only), 1 = multi display (all latched)
ack  input  1  operator acknowledge, level sampled every clk
led  output  4  LED drive, same bit order as haz
buzzer  output  1  audible alert
alarm  output  1  1 whenever state != IDLE
state  output  2  00 IDLE, 01 ALERT, 10 ACKED (11 never reached)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high (rst). rst dominates every other input.
- Reset values: all per-hazard counters, latched, acked_mask, clear counter and beep counter = 0; state = IDLE; buzzer = 0; alarm = 0; led = 0.
- Persistence filter, per bit i, 4-bit counter pc[i]:
  - On tick: if haz[i], pc[i] = min(pc[i]+1, PERSIST); else pc[i] = 0.
  - No change when tick=0.
  - conf[i] = (pc[i] == PERSIST), decoded from registers.
- Latch: latched[i] is set on the clk after conf[i] is observed high. It stays set regardless of haz and clears only on the ACKED->IDLE transition.
- FSM, transitions evaluated every clk:
  - IDLE: if any conf -> ALERT. On entry to ALERT, buzzer = 1 and beep counter = 0. ack is ignored in IDLE.
  - ALERT:
    - Beep counter increments on tick. When it reaches BEEP_DIV, buzzer toggles and the counter returns to 0.
    - ack=1 -> ACKED, with acked_mask = latched | conf (same-cycle new confirmations count as acknowledged), buzzer = 0, clear counter = 0.
    - ALERT never self-clears.
  - ACKED:
    - buzzer held 0.
    - On tick: if haz == 0, clear counter++; else clear counter = 0.
    - If (conf & ~acked_mask) != 0 -> ALERT (re-alert; buzzer = 1, beep counter = 0). This has priority over clearing.
    - Else if the clear counter reaches CLEAR -> IDLE, clearing latched, acked_mask and clear counter.
    - ack is ignored in ACKED.
- Latency: with haz[i] held from tick #1, pc[i] = PERSIST after tick #PERSIST. latched[i], state = ALERT and buzzer = 1 appear on the clk edge after that.
- led, combinational from registers and mode:
  - mode=1: led = latched.
  - mode=0: one-hot of the highest-priority latched bit, priority flood > cyclone > earthquake > tsunami; 0000 if latched = 0.
  - Changing mode takes effect the same cycle and never alters latched or state.
- Counter wrap: all counters saturate or reset as specified; none ever wrap.
- A hazard dropping for one tick resets its pc[i] (no partial credit).
- alarm = (state != IDLE).

Test Plan:
- Reset, then haz=1000 held with tick every 4 clks, PERSIST=3 -> after tick 3, next clk: state=01, alarm=1, buzzer=1, led=1000. Buzzer toggles every 2 ticks.
- haz=0100 for 2 ticks, 0000 for 1 tick, 0100 for 2 ticks (PERSIST=3) -> never confirmed: state=00, led=0000 throughout.
- Confirm haz=0011 with mode=0 -> led=0010; switch mode=1 -> led=0011 same cycle; state unchanged at 01.
- In ALERT, pulse ack -> state=10, buzzer=0. Hold haz=0000 for 4 ticks -> state=00, led=0000, alarm=0. With 3 clear ticks then haz=0001 for 1 tick, the clear counter restarts.
- In ACKED with acked_mask=0010, confirm flood (haz=1010) -> state=01, buzzer=1, led=1000 (mode=0). A second ack -> state=10.
- Assert rst mid-ALERT with buzzer=1 -> next clk: all outputs 0, state=00. Hazard re-confirmation needs PERSIST full ticks.
